// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: bus widths, stall encodings and FSM states shared by the fetch stage.
package if_fetch_stage_pkg;
    localparam int IF_TO_ID_WD = 33;
    localparam int BR_WD       = 33;
    localparam int STALL_BUS   = 6;
    localparam logic STOP      = 1'b1;
    localparam logic NO_STOP   = 1'b0;
    typedef enum logic [1:0] {
        IF_S_REQ  = 2'd0,
        IF_S_WAIT = 2'd1,
        IF_S_HOLD = 2'd2
    } if_state_e;
endpackage

// File: rtl/if_br_latch.sv
// if_br_latch: holds the last branch redirect from decode and selects the next fetch PC.
module if_br_latch
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] PC_STEP = 32'd4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [BR_WD-1:0] i_br_bus,
    input  logic             i_take,
    input  logic [31:0]      i_cur_pc,
    output logic [31:0]      o_next_pc
);
    logic        w_br_e;
    logic [31:0] w_br_addr;
    logic        r_br_pend;
    logic [31:0] r_br_tgt;

    assign {w_br_e, w_br_addr} = i_br_bus;
    // A redirect arriving in the same cycle as the PC update is bypassed straight through.
    assign o_next_pc = w_br_e ? w_br_addr : r_br_pend ? r_br_tgt : i_cur_pc + PC_STEP;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_br_pend <= 1'b0;
            r_br_tgt  <= '0;
        end else begin
            if (w_br_e) r_br_tgt <= w_br_addr;
            r_br_pend <= i_take ? 1'b0 : (r_br_pend | w_br_e);
        end
    end
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC register and single-outstanding fetch FSM (REQ/WAIT/HOLD) feeding decode.
// Optional IF_PC_ALIGN_CHECK_EN adds o_adel and turns misaligned PCs into a nop without fetching.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [STALL_BUS-1:0]   i_stall,
    input  logic [BR_WD-1:0]       i_br_bus,
    output logic                   o_inst_req,
    output logic [31:0]            o_inst_addr,
    input  logic                   i_inst_addr_ok,
    input  logic                   i_inst_data_ok,
    input  logic [31:0]            i_inst_rdata,
    output logic [IF_TO_ID_WD-1:0] o_if_to_id_bus,
    output logic [31:0]            o_if_inst,
`ifdef IF_PC_ALIGN_CHECK_EN
    output logic                   o_adel,
`endif
    output logic                   o_stallreq
);
    if_state_e   r_state, w_state_nxt;
    logic        r_go;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_inst_buf;
    logic [31:0] w_next_pc;
    logic        w_leave;
    logic        w_misalign;
    logic        w_unused;

    assign w_unused = ^i_stall[STALL_BUS-1:1];
    assign w_leave  = (r_state == IF_S_HOLD) && (i_stall[0] == NO_STOP);

    if_br_latch #(.PC_STEP(PC_STEP)) u_br_latch (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_br_bus  (i_br_bus),
        .i_take    (w_leave),
        .i_cur_pc  (r_fetch_pc),
        .o_next_pc (w_next_pc)
    );

`ifdef IF_PC_ALIGN_CHECK_EN
    logic r_adel;
    assign w_misalign  = |w_next_pc[1:0];
    assign o_adel      = r_adel;
    assign o_inst_addr = r_fetch_pc;
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_adel <= 1'b0;
        else if (w_leave) r_adel <= w_misalign;
    end
`else
    assign w_misalign  = 1'b0;
    assign o_inst_addr = {r_fetch_pc[31:2], 2'b00};
`endif

    // r_go keeps the request low for the first cycle out of reset.
    assign o_inst_req     = r_go && (r_state == IF_S_REQ);
    assign o_stallreq     = r_go && (r_state != IF_S_HOLD);
    assign o_if_to_id_bus = r_go ? {r_state == IF_S_HOLD, r_fetch_pc} : '0;
    assign o_if_inst      = r_inst_buf;

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IF_S_REQ:  w_state_nxt = (o_inst_req && i_inst_addr_ok) ? IF_S_WAIT : IF_S_REQ;
            IF_S_WAIT: w_state_nxt = i_inst_data_ok ? IF_S_HOLD : IF_S_WAIT;
            IF_S_HOLD: w_state_nxt = (w_leave && !w_misalign) ? IF_S_REQ : IF_S_HOLD;
            default:   w_state_nxt = IF_S_REQ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state    <= IF_S_REQ;
            r_go       <= 1'b0;
            r_fetch_pc <= RESET_PC;
            r_inst_buf <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_go    <= 1'b1;
            if (w_leave) r_fetch_pc <= w_next_pc;
            if (r_state == IF_S_WAIT && i_inst_data_ok) r_inst_buf <= i_inst_rdata;
            else if (w_leave && w_misalign) r_inst_buf <= '0;
        end
    end
endmodule
